// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the PLL reset sequencer.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 4;

  localparam logic [7:0] LOSS_SAT = 8'hFF;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: hold PLL in reset, wait for lock with timeout/retry,
// qualify lock stability, then release the downstream reset until lock is lost.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] loss_count
);

  localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RET_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RET_W-1:0] RETRY_LIM   = RET_W'(MAX_RETRIES);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RET_W-1:0] retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             lk;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (restart) begin
      state_d = PLL_RST;
      retry_d = '0;
    end else begin
      unique case (state_q)
        PLL_RST: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          cnt_d = cnt_q + 1'b1;
          if (lk) begin
            state_d = STABLE;
          end else if (cnt_q == LOCK_LAST) begin
            retry_d = retry_q + 1'b1;
            state_d = (retry_d >= RETRY_LIM) ? FAIL : PLL_RST;
          end
        end
        STABLE: begin
          cnt_d = cnt_q + 1'b1;
          if (!lk) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN: begin
          if (!lk) begin
            state_d = PLL_RST;
            if (loss_q != LOSS_SAT) loss_d = loss_q + 1'b1;
          end
        end
        FAIL: begin
        end
        default: state_d = PLL_RST;
      endcase
    end

    // Restart re-arms the reset hold even when already in PLL_RST.
    if (restart || (state_d != state_q)) cnt_d = '0;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  assign pll_rst    = (state_q == PLL_RST);
  assign sys_rst_n  = (state_q == RUN);
  assign ready      = (state_q == RUN);
  assign fail       = (state_q == FAIL);
  assign state      = state_q;
  assign loss_count = loss_q;

endmodule

// File: doc/pll_reset_ctrl.md
PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16, the number of cycles the PLL reset is held per attempt (minimum 1).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 65536, the number of cycles to wait for lock before retrying.
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 1024, the number of consecutive synchronized-locked cycles required before release.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 4, the number of consecutive failed attempts before entering FAIL.
REQ-005 The block SHALL have port refclk, input, 1 bit: the single clock (50 MHz PLL reference).
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port restart, input, 1 bit: a synchronous single-cycle request to re-sequence the PLL.
REQ-008 The block SHALL have port pll_locked, input, 1 bit: the PLL locked flag, asynchronous to refclk.
REQ-009 The block SHALL have port pll_rst, output, 1 bit: active-high PLL reset.
REQ-010 The block SHALL have port sys_rst_n, output, 1 bit: active-low reset for logic clocked by the PLL outputs.
REQ-011 The block SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-012 The block SHALL have port fail, output, 1 bit: high only in state FAIL.
REQ-013 The block SHALL have port state, output, 3 bits: the current state encoding.
REQ-014 The block SHALL have port loss_count, output, 8 bits: a saturating count of lock losses seen in RUN.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value lk.
REQ-016 The states SHALL be PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4; encodings 5-7 SHALL go to PLL_RST on the next cycle.
REQ-017 PLL_RST: pll_rst SHALL be 1; the state SHALL go to WAIT_LOCK after exactly RST_CYCLES cycles in PLL_RST.
REQ-018 WAIT_LOCK: pll_rst SHALL be 0; lk=1 SHALL go to STABLE; after LOCK_TIMEOUT cycles with lk=0 the retry counter SHALL increment.
REQ-019 On that increment, the state SHALL go to FAIL if the counter reaches MAX_RETRIES, else to PLL_RST.
REQ-020 STABLE: after STABLE_CYCLES consecutive cycles of lk=1 the state SHALL go to RUN and the retry counter SHALL clear.
REQ-021 STABLE: any cycle with lk=0 SHALL return the state to WAIT_LOCK and restart the WAIT_LOCK timeout.
REQ-022 RUN: lk=0 SHALL go to PLL_RST and increment loss_count, saturating at 255.
REQ-023 FAIL: pll_rst SHALL be 0 and the state SHALL be held until restart or reset.
REQ-024 restart=1 in any state SHALL go to PLL_RST next cycle, clear the retry counter, and leave loss_count unchanged.
REQ-025 restart SHALL take priority over every other transition in the same cycle.
REQ-026 sys_rst_n SHALL be 1 only in RUN.
REQ-027 sys_rst_n SHALL drop to 0 combinationally from the state register in the same cycle the state leaves RUN (no extra latency).
REQ-028 All outputs SHALL be registered or decoded from registered state only, and SHALL NOT depend combinationally on pll_locked or restart.
REQ-029 A single shared cycle counter SHALL be used, wide enough for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES), and zeroed on every state change.

Reset
REQ-030 rst_n=0 SHALL asynchronously set state=PLL_RST, pll_rst=1, sys_rst_n=0, ready=0, fail=0, loss_count=0, and clear the retry counter, cycle counter and synchronizer.
REQ-031 rst_n assertion mid-sequence SHALL abort the sequence; after release, sequencing SHALL restart from PLL_RST with a full RST_CYCLES hold.

Structure
REQ-032 The state enum, state encodings and parameter defaults SHALL live in shared package pll_ctrl_pkg.
REQ-033 The locked synchronizer SHALL be a separate sub-module sync_2ff, with async active-low reset and reset value 0.

Verification
REQ-034 Directed scenarios SHALL use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-035 Scenario: release rst_n, raise pll_locked at cycle 10 -> pll_rst high exactly 4 cycles, then WAIT_LOCK; ready=1 and sys_rst_n=1 on the 8th cycle of lk=1 in STABLE.
REQ-036 Scenario: pll_locked held 0 -> two PLL_RST pulses of 4 cycles, each attempt timing out after 32 cycles; after the 2nd timeout fail=1, state=4, pll_rst=0.
REQ-037 Scenario: in STABLE, a 1-cycle lk glitch at count 5 -> return to WAIT_LOCK and a full 8-cycle qualification afterwards.
REQ-038 Scenario: in RUN, drop pll_locked -> after 2 synchronizer cycles the state leaves RUN and sys_rst_n=0 that cycle; loss_count=1; the cycle then repeats to RUN.
REQ-039 Scenario: force 256 lock losses -> loss_count saturates at 255; restart in FAIL -> PLL_RST next cycle with fail=0.
REQ-040 Scenario: assert rst_n mid-STABLE -> all outputs take reset values immediately, without waiting for a refclk edge.
